// File: rtl/rsm_pkg.sv
// Shared types and encodings for the Simple RISC Machine sequencer.
package rsm_pkg;

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPD_PC  = 5'd3,
        S_DECODE  = 5'd4,
        S_WR_IMM  = 5'd5,
        S_GET_A   = 5'd6,
        S_GET_B   = 5'd7,
        S_ALU     = 5'd8,
        S_WR_REG  = 5'd9,
        S_ADDR    = 5'd10,
        S_LD_ADDR = 5'd11,
        S_MEM_RD  = 5'd12,
        S_WB      = 5'd13,
        S_GET_D   = 5'd14,
        S_PASS    = 5'd15,
        S_MEM_WR  = 5'd16,
        S_HALT    = 5'd17,
        S_FAULT   = 5'd18
    } state_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_MDATA = 2'b10;
    localparam logic [1:0] VSEL_IMM   = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    function automatic logic is_mem_op(input logic [2:0] opcode, input logic [1:0] op);
        return ((opcode == OPC_LDR) || (opcode == OPC_STR)) && (op == OP_MEM);
    endfunction

endpackage

// File: rtl/rsm_mem_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles inside a wait state
// and flags the cycle in which the count would reach MEM_TIMEOUT.
module rsm_mem_timer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_wait,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam int              CW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0]   MAXV = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_count;

    // Leaving a wait state clears the count, so every entry starts from zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (!i_wait) begin
            r_count <= '0;
        end else if (!i_mem_ready && (r_count != MAXV)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_timeout = i_wait && !i_mem_ready && (r_count == LAST);

endmodule

// File: rtl/rsm_sequencer.sv
// Moore instruction sequencer for the Simple RISC Machine datapath.
// Define RSM_MEM_READY_EN to honour mem_ready in wait states and add the FAULT watchdog.
module rsm_sequencer
    import rsm_pkg::*;
`ifdef RSM_MEM_READY_EN
#(
    parameter int MEM_TIMEOUT = 8
)
`endif
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_opcode,
    input  logic [1:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_reset_pc,
    output logic       o_load_pc,
    output logic       o_load_ir,
    output logic       o_load_addr,
    output logic       o_addr_sel,
    output logic [1:0] o_mem_cmd,
    output logic       o_loada,
    output logic       o_loadb,
    output logic       o_loadc,
    output logic       o_loads,
    output logic       o_asel,
    output logic       o_bsel,
    output logic [1:0] o_vsel,
    output logic [2:0] o_nsel,
    output logic       o_write,
    output logic       o_halted,
    output logic       o_fault
);

    state_t r_state;
    state_t w_next;
    logic   w_ready;
    logic   w_timeout;

`ifdef RSM_MEM_READY_EN
    logic w_waiting;

    assign w_waiting = (r_state == S_IF2) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_ready   = i_mem_ready;

    rsm_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wait      (w_waiting),
        .i_mem_ready (i_mem_ready),
        .o_timeout   (w_timeout)
    );
`else
    logic w_unused_mem_ready;

    assign w_unused_mem_ready = i_mem_ready;
    assign w_ready            = 1'b1;
    assign w_timeout          = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_IF1;
            S_IF1:    w_next = S_IF2;
            S_IF2: begin
                if (w_ready)        w_next = S_UPD_PC;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_UPD_PC: w_next = S_DECODE;
            S_DECODE: begin
                if ((i_opcode == OPC_MOV) && (i_op == OP_MOV_IMM))      w_next = S_WR_IMM;
                else if ((i_opcode == OPC_MOV) && (i_op == OP_MOV_REG)) w_next = S_GET_B;
                else if ((i_opcode == OPC_ALU) && (i_op == OP_MVN))     w_next = S_GET_B;
                else if (i_opcode == OPC_ALU)                           w_next = S_GET_A;
                else if (is_mem_op(i_opcode, i_op))                     w_next = S_GET_A;
                else if (i_opcode == OPC_HALT)                          w_next = S_HALT;
                else                                                    w_next = S_IF1;
            end
            S_WR_IMM: w_next = S_IF1;
            S_GET_A:  w_next = is_mem_op(i_opcode, i_op) ? S_ADDR : S_GET_B;
            S_GET_B:  w_next = S_ALU;
            S_ALU:    w_next = ((i_opcode == OPC_ALU) && (i_op == OP_CMP)) ? S_IF1 : S_WR_REG;
            S_WR_REG: w_next = S_IF1;
            S_ADDR:   w_next = S_LD_ADDR;
            S_LD_ADDR: w_next = (i_opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
            S_MEM_RD: begin
                if (w_ready)        w_next = S_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_WB:     w_next = S_IF1;
            S_GET_D:  w_next = S_PASS;
            S_PASS:   w_next = S_MEM_WR;
            S_MEM_WR: begin
                if (w_ready)        w_next = S_IF1;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_HALT:   w_next = S_HALT;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_RST;
        endcase
    end

    // Strobes depend on the state register only; asel in ALU also looks at the held IR fields.
    always_comb begin
        o_reset_pc  = 1'b0;
        o_load_pc   = 1'b0;
        o_load_ir   = 1'b0;
        o_load_addr = 1'b0;
        o_addr_sel  = 1'b0;
        o_mem_cmd   = MEM_NONE;
        o_loada     = 1'b0;
        o_loadb     = 1'b0;
        o_loadc     = 1'b0;
        o_loads     = 1'b0;
        o_asel      = 1'b0;
        o_bsel      = 1'b0;
        o_vsel      = VSEL_C;
        o_nsel      = NSEL_NONE;
        o_write     = 1'b0;
        o_halted    = 1'b0;
`ifdef RSM_MEM_READY_EN
        o_fault     = 1'b0;
`endif
        case (r_state)
            S_RST: begin
                o_reset_pc = 1'b1;
                o_load_pc  = 1'b1;
            end
            S_IF1: begin
                o_addr_sel = 1'b1;
                o_mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                o_addr_sel = 1'b1;
                o_mem_cmd  = MEM_READ;
                o_load_ir  = 1'b1;
            end
            S_UPD_PC: o_load_pc = 1'b1;
            S_WR_IMM: begin
                o_vsel  = VSEL_IMM;
                o_nsel  = NSEL_RN;
                o_write = 1'b1;
            end
            S_GET_A: begin
                o_nsel  = NSEL_RN;
                o_loada = 1'b1;
            end
            S_GET_B: begin
                o_nsel  = NSEL_RM;
                o_loadb = 1'b1;
            end
            S_ALU: begin
                o_loadc = 1'b1;
                o_loads = 1'b1;
                o_asel  = (i_opcode == OPC_MOV) && (i_op == OP_MOV_REG);
            end
            S_WR_REG: begin
                o_vsel  = VSEL_C;
                o_nsel  = NSEL_RD;
                o_write = 1'b1;
            end
            S_ADDR: begin
                o_bsel  = 1'b1;
                o_loadc = 1'b1;
            end
            S_LD_ADDR: o_load_addr = 1'b1;
            S_MEM_RD:  o_mem_cmd   = MEM_READ;
            S_WB: begin
                o_mem_cmd = MEM_READ;
                o_vsel    = VSEL_MDATA;
                o_nsel    = NSEL_RD;
                o_write   = 1'b1;
            end
            S_GET_D: begin
                o_nsel  = NSEL_RD;
                o_loadb = 1'b1;
            end
            S_PASS: begin
                o_asel  = 1'b1;
                o_loadc = 1'b1;
            end
            S_MEM_WR: o_mem_cmd = MEM_WRITE;
            S_HALT:   o_halted  = 1'b1;
`ifdef RSM_MEM_READY_EN
            S_FAULT:  o_fault   = 1'b1;
`endif
            default: ;
        endcase
    end

`ifndef RSM_MEM_READY_EN
    assign o_fault = 1'b0;
`endif

endmodule

// File: doc/rsm_sequencer.md
Name: rsm_sequencer

Overview:
- Multi-cycle instruction sequencer for the Simple RISC Machine datapath.
- Adds fetch, PC update, LDR/STR memory access and HALT on top of the existing register-file / ALU / shifter datapath.
- Drives the datapath load/select strobes and a memory command port. The instruction decoder supplies opcode, op, and the Rn/Rd/Rm field selection via nsel.

Parameters:
MEM_TIMEOUT, 8, consecutive cycles mem_ready may stay low in a memory-wait state before FAULT (used only with RSM_MEM_READY_EN).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
mem_ready  in  1  memory completed current command
reset_pc  out  1  PC next value is 0
load_pc  out  1  PC register enable
load_ir  out  1  instruction register enable
load_addr  out  1  data-address register enable
addr_sel  out  1  1=PC drives mem_addr, 0=data-address register
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
loada, loadb, loadc, loads  out  1 each  datapath register enables
asel  out  1  1=A operand forced to 0
bsel  out  1  1=B operand is sximm5
vsel  out  2  00 C, 01 PC, 10 mdata, 11 sximm8
nsel  out  3  one-hot: 001 Rn, 010 Rd, 100 Rm; 000 none
write  out  1  register-file write enable
halted  out  1  in HALT
fault  out  1  in FAULT

Behaviour:
- Moore FSM: all outputs decode from the state register only. Every strobe not listed for a state is 0 (nsel=000, vsel=00, mem_cmd=NONE).
- Reset: while reset=0, state=RST and counter=0. Outputs: reset_pc=1, load_pc=1, all others 0. Assertion mid-instruction aborts it immediately. No partial register write occurs after the reset edge.
- RST: reset_pc, load_pc -> IF1.
- IF1: addr_sel, READ -> IF2.
- IF2: addr_sel, READ, load_ir. Advances to UPD_PC when mem_ready=1; otherwise holds, and load_ir is re-asserted each cycle.
- UPD_PC: load_pc -> DECODE.
- DECODE, no strobes:
  - 110/10 -> WR_IMM
  - 110/00 -> GET_B
  - 101/11 -> GET_B
  - 101/other -> GET_A
  - 011/00 or 100/00 -> GET_A
  - 111/xx -> HALT
  - else -> IF1 (NOP)
- WR_IMM: vsel=11, nsel=Rn, write -> IF1.
- GET_A: nsel=Rn, loada. Next state: ADDR for LDR/STR, else GET_B.
- GET_B: nsel=Rm, loadb -> ALU.
- ALU: loadc, loads; asel=1 for MOV-reg. 101/01 (CMP) -> IF1, else -> WR_REG.
- WR_REG: vsel=00, nsel=Rd, write -> IF1.
- ADDR: bsel, loadc -> LD_ADDR.
- LD_ADDR: load_addr. LDR -> MEM_RD; STR -> GET_D.
- MEM_RD: addr_sel=0, READ. Holds until mem_ready -> WB.
- WB: READ, vsel=10, nsel=Rd, write -> IF1.
- GET_D: nsel=Rd, loadb -> PASS.
- PASS: asel, loadc -> MEM_WR.
- MEM_WR: WRITE. Holds until mem_ready -> IF1.
- HALT: halted=1. Absorbing until reset.
- Latencies with mem_ready=1:
  - MOV imm: 5 cycles IF1->IF1.
  - ALU: 8 cycles.
  - CMP: 7 cycles.
  - LDR: 9 cycles.
  - STR: 10 cycles.
- mem_ready outside the wait states (IF2, MEM_RD, MEM_WR) is ignored.

Optional Feature:
- Macro: RSM_MEM_READY_EN.
- Defined:
  - A counter (clog2(MEM_TIMEOUT+1) bits) clears on entry to each wait state. It increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT, the next state is FAULT. In FAULT, fault=1 and all other outputs are 0; FAULT is absorbing until reset.
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT wins; the FSM advances normally.
- Undefined:
  - mem_ready is ignored and every wait state advances after one cycle.
  - The FAULT state, counter and MEM_TIMEOUT logic are absent, and fault is tied to 0.

Decomposition:
- Package rsm_pkg holds:
  - state enum
  - opcode/op constants (MOV, ALU, LDR, STR, HALT)
  - mem_cmd encodings
  - vsel encodings
  - nsel one-hot constants
- Sub-module rsm_mem_timer: the wait counter and timeout flag, instantiated only under RSM_MEM_READY_EN.

Test Plan:
- Reset low for 2 cycles, release, mem_ready=1, IR=MOV R0,#5 (110/10) -> reset_pc/load_pc in RST, IF1, IF2, UPD_PC, DECODE, WR_IMM with vsel=11, nsel=001, write=1 -> back to IF1 on cycle 6.
- ADD (101/00) -> loada (nsel=001), loadb (nsel=100), loadc+loads, write (nsel=010, vsel=00); CMP (101/01) -> no write, returns to IF1 after ALU.
- LDR with mem_ready low 3 cycles in MEM_RD -> FSM holds 4 cycles in MEM_RD with addr_sel=0, READ; then WB vsel=10, write=1.
- STR -> load_addr in LD_ADDR, loadb with nsel=010 in GET_D, asel=1 in PASS, mem_cmd=10 in MEM_WR; a HALT fetched next -> halted=1 persists 20 cycles; reset clears it.
- Reset deasserted-then-asserted during MEM_WR -> mem_cmd drops to 00 combinationally with reset, no write; state RST.
- With RSM_MEM_READY_EN, MEM_TIMEOUT=8, mem_ready held 0 in IF2 -> fault=1 after 8 wait cycles. A separate run with mem_ready=1 on the 8th wait cycle -> normal UPD_PC.
